// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: issues req/ack bus transactions for loads/stores,
// formats load data for MEM/WB, stalls the pipeline while busy, and flags AdEL/AdES/DBE.
module mem_access_unit #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  MemSize,
  input  logic        MemSigned,
  input  logic [31:0] ALU_result,
  input  logic [31:0] WriteData,
  input  logic        kill,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic [31:0] MemData,
  output logic        mem_stall,
  output logic        mem_exc,
  output logic [4:0]  exc_code,
  output logic [31:0] bad_vaddr
);

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_DBE  = 5'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        addr_q;
  logic [1:0]         size_q;
  logic               sgn_q;
  logic               killed_q;
  logic               dbe_q;
  logic [4:0]         exc_code_q;

  logic               access, misaligned, in_idle, start, mis_exc, tmo, discard;

  function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'b00:   lane_enables = 4'b0001 << lane;
      2'b01:   lane_enables = lane[1] ? 4'b1100 : 4'b0011;
      default: lane_enables = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] replicate_store(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      2'b00:   replicate_store = {4{wd[7:0]}};
      2'b01:   replicate_store = {2{wd[15:0]}};
      default: replicate_store = wd;
    endcase
  endfunction

  function automatic logic [31:0] format_load(input logic [31:0] rdata, input logic [1:0] size,
                                              input logic sgn, input logic [1:0] lane);
    logic [31:0] shifted;
    shifted = rdata >> {lane, 3'b000};
    case (size)
      2'b00:   format_load = {{24{sgn & shifted[7]}}, shifted[7:0]};
      2'b01:   format_load = {{16{sgn & shifted[15]}}, shifted[15:0]};
      default: format_load = rdata;
    endcase
  endfunction

  always_comb begin
    case (MemSize)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = ALU_result[0];
      default: misaligned = (ALU_result[1:0] != 2'b00);
    endcase
  end

  // A pending bus-error pulse means the instruction in MEM has faulted; it must not restart.
  assign access   = (MemRead | MemWrite) & ~kill;
  assign in_idle  = (state == ST_IDLE);
  assign start    = in_idle & access & ~misaligned & ~dbe_q;
  assign mis_exc  = in_idle & access & misaligned & ~dbe_q;
  assign tmo      = (state == ST_WAIT) & ~bus_ack & (cnt == CNT_W'(TIMEOUT - 1));
  assign discard  = kill | killed_q;

  assign mem_stall = start | (state == ST_WAIT);
  assign mem_exc   = mis_exc | dbe_q;
  assign exc_code  = mis_exc ? (MemWrite ? EXC_ADES : EXC_ADEL) : exc_code_q;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (bus_ack)  state_nxt = discard ? ST_IDLE : ST_DONE;
        else if (tmo) state_nxt = ST_IDLE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_be     <= '0;
      bus_wdata  <= '0;
      MemData    <= '0;
      exc_code_q <= '0;
      bad_vaddr  <= '0;
      cnt        <= '0;
      addr_q     <= '0;
      size_q     <= '0;
      sgn_q      <= 1'b0;
      killed_q   <= 1'b0;
      dbe_q      <= 1'b0;
    end else begin
      state <= state_nxt;
      dbe_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            bus_req   <= 1'b1;
            bus_we    <= MemWrite;
            bus_addr  <= {ALU_result[31:2], 2'b00};
            bus_be    <= lane_enables(MemSize, ALU_result[1:0]);
            bus_wdata <= replicate_store(MemSize, WriteData);
            addr_q    <= ALU_result;
            size_q    <= MemSize;
            sgn_q     <= MemSigned;
            cnt       <= '0;
            killed_q  <= 1'b0;
          end
          if (mis_exc) begin
            exc_code_q <= MemWrite ? EXC_ADES : EXC_ADEL;
            bad_vaddr  <= ALU_result;
          end
        end
        ST_WAIT: begin
          killed_q <= killed_q | kill;
          if (bus_ack) begin
            bus_req <= 1'b0;
            if (!bus_we && !discard)
              MemData <= format_load(bus_rdata, size_q, sgn_q, addr_q[1:0]);
          end else begin
            cnt <= cnt + 1'b1;
            if (tmo) begin
              bus_req <= 1'b0;
              // A flushed instruction cannot take an exception.
              if (!discard) begin
                dbe_q      <= 1'b1;
                exc_code_q <= EXC_DBE;
                bad_vaddr  <= addr_q;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: vector table, hand-written timeout/kill/reset sequences,
// and random accesses checked against a byte-lane reference model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite, MemSigned, kill, bus_ack;
  logic [1:0]  MemSize;
  logic [31:0] ALU_result, WriteData, bus_rdata;
  logic        bus_req, bus_we, mem_stall, mem_exc;
  logic [31:0] bus_addr, bus_wdata, MemData, bad_vaddr;
  logic [3:0]  bus_be;
  logic [4:0]  exc_code;

  int checks   = 0;
  int failures = 0;
  logic [31:0] cur_md;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite), .MemSize(MemSize),
    .MemSigned(MemSigned), .ALU_result(ALU_result), .WriteData(WriteData), .kill(kill),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack), .MemData(MemData),
    .mem_stall(mem_stall), .mem_exc(mem_exc), .exc_code(exc_code), .bad_vaddr(bad_vaddr)
  );

  typedef struct {
    logic        rd, wr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr, wd, rdata;
    int          wait_n;
    logic        mis;
    logic [4:0]  code;
    logic [3:0]  be;
    logic [31:0] wdata, md;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [1:0] size,
      input logic sgn, input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdata,
      input int wait_n, input logic mis, input logic [4:0] code, input logic [3:0] be,
      input logic [31:0] wdata, input logic [31:0] md);
    vec_t v;
    v.rd = rd; v.wr = wr; v.size = size; v.sgn = sgn; v.addr = addr; v.wd = wd;
    v.rdata = rdata; v.wait_n = wait_n; v.mis = mis; v.code = code; v.be = be;
    v.wdata = wdata; v.md = md;
    return v;
  endfunction

  // Reference model: access width in bytes, selected byte range, byte-wise assembly.
  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic vec_t model(input logic rd, input logic wr, input logic [1:0] size,
      input logic sgn, input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdata,
      input int wait_n);
    vec_t v;
    int n, first, off;
    logic [7:0] b;
    n     = nbytes(size);
    off   = int'(addr % 4);
    first = (off / n) * n;
    v = mk(rd, wr, size, sgn, addr, wd, rdata, wait_n, 1'b0, 5'd0, 4'd0, 32'd0, 32'd0);
    v.mis  = (off % n) != 0;
    v.code = wr ? 5'd5 : 5'd4;
    for (int i = 0; i < 4; i++) begin
      v.be[i] = (i >= first) && (i < first + n);
      b = wd[8*(i % n) +: 8];
      v.wdata[8*i +: 8] = b;
    end
    for (int j = 0; j < n; j++) begin
      b = rdata[8*(first + j) +: 8];
      v.md = v.md | (32'(b) << (8*j));
    end
    if (sgn && n < 4 && v.md[8*n-1])
      v.md = v.md | ~((32'd1 << (8*n)) - 32'd1);
    return v;
  endfunction

  task automatic clear_inputs();
    MemRead = 0; MemWrite = 0; MemSize = 0; MemSigned = 0;
    ALU_result = 0; WriteData = 0; kill = 0;
  endtask

  task automatic apply(input string tag, input vec_t v);
    @(posedge clk); #1;
    MemRead = v.rd; MemWrite = v.wr; MemSize = v.size; MemSigned = v.sgn;
    ALU_result = v.addr; WriteData = v.wd;
    @(negedge clk);
    if (v.mis) begin
      chk({tag, ".mis_exc"}, mem_exc, 1);
      chk({tag, ".mis_code"}, exc_code, v.code);
      chk({tag, ".mis_stall"}, mem_stall, 0);
      chk({tag, ".mis_req"}, bus_req, 0);
      @(posedge clk); #1;
      clear_inputs();
      @(negedge clk);
      chk({tag, ".bad_vaddr"}, bad_vaddr, v.addr);
      chk({tag, ".req_after"}, bus_req, 0);
      chk({tag, ".exc_after"}, mem_exc, 0);
    end else begin
      chk({tag, ".idle_stall"}, mem_stall, 1);
      chk({tag, ".idle_exc"}, mem_exc, 0);
      for (int k = 1; k <= v.wait_n; k++) begin
        @(posedge clk); #1;
        if (k == v.wait_n) begin
          bus_ack = 1; bus_rdata = v.rdata;
        end else begin
          bus_rdata = $urandom;
        end
        @(negedge clk);
        chk({tag, ".wait_stall"}, mem_stall, 1);
        chk({tag, ".wait_req"}, bus_req, 1);
        if (k == 1) begin
          chk({tag, ".addr"}, bus_addr, {v.addr[31:2], 2'b00});
          chk({tag, ".be"}, bus_be, v.be);
          chk({tag, ".we"}, bus_we, v.wr);
          if (v.wr) chk({tag, ".wdata"}, bus_wdata, v.wdata);
        end
      end
      @(posedge clk); #1;
      bus_ack = 0;
      @(negedge clk);
      if (!v.wr) cur_md = v.md;
      chk({tag, ".done_stall"}, mem_stall, 0);
      chk({tag, ".done_req"}, bus_req, 0);
      chk({tag, ".memdata"}, MemData, cur_md);
      @(posedge clk); #1;
      clear_inputs();
    end
  endtask

  vec_t tbl[12];
  vec_t rv;

  initial begin
    #200000;
    $display("FAIL watchdog time=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = mk(1, 0, 2'd2, 0, 32'h100, 32'h0, 32'hDEADBEEF, 2, 0, 5'd0, 4'b1111, 32'h0, 32'hDEADBEEF);
    tbl[1]  = mk(1, 0, 2'd0, 1, 32'h103, 32'h0, 32'h80FF0000, 1, 0, 5'd0, 4'b1000, 32'h0, 32'hFFFFFF80);
    tbl[2]  = mk(1, 0, 2'd0, 0, 32'h103, 32'h0, 32'h80FF0000, 1, 0, 5'd0, 4'b1000, 32'h0, 32'h00000080);
    tbl[3]  = mk(0, 1, 2'd1, 0, 32'h202, 32'h1234ABCD, 32'h0, 1, 0, 5'd0, 4'b1100, 32'hABCDABCD, 32'h0);
    tbl[4]  = mk(1, 0, 2'd2, 0, 32'h101, 32'h0, 32'h0, 1, 1, 5'd4, 4'b0000, 32'h0, 32'h0);
    tbl[5]  = mk(0, 1, 2'd1, 0, 32'h301, 32'h5555, 32'h0, 1, 1, 5'd5, 4'b0000, 32'h0, 32'h0);
    tbl[6]  = mk(1, 0, 2'd1, 1, 32'h002, 32'h0, 32'h80017FFF, 3, 0, 5'd0, 4'b1100, 32'h0, 32'hFFFF8001);
    tbl[7]  = mk(0, 1, 2'd0, 0, 32'h041, 32'h0000005A, 32'h0, 1, 0, 5'd0, 4'b0010, 32'h5A5A5A5A, 32'h0);
    tbl[8]  = mk(1, 0, 2'd3, 1, 32'h008, 32'h0, 32'h12345678, 4, 0, 5'd0, 4'b1111, 32'h0, 32'h12345678);
    tbl[9]  = mk(1, 1, 2'd2, 0, 32'h010, 32'hCAFEF00D, 32'h0, 1, 0, 5'd0, 4'b1111, 32'hCAFEF00D, 32'h0);
    tbl[10] = mk(1, 0, 2'd0, 0, 32'h007, 32'h0, 32'h7F000000, 2, 0, 5'd0, 4'b1000, 32'h0, 32'h0000007F);
    tbl[11] = mk(1, 0, 2'd1, 0, 32'h102, 32'h0, 32'hBEEF1234, 1, 0, 5'd0, 4'b1100, 32'h0, 32'h0000BEEF);

    clear_inputs();
    bus_ack = 0; bus_rdata = 0; reset = 1; cur_md = 0;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst.req", bus_req, 0);
    chk("rst.addr", bus_addr, 0);
    chk("rst.be", bus_be, 0);
    chk("rst.memdata", MemData, 0);
    chk("rst.exc_code", exc_code, 0);
    chk("rst.bad_vaddr", bad_vaddr, 0);
    chk("rst.stall", mem_stall, 0);
    chk("rst.exc", mem_exc, 0);

    for (int i = 0; i < 12; i++) apply($sformatf("tbl%0d", i), tbl[i]);

    // Bus timeout: exactly four WAIT cycles, then DBE; a late ack is ignored.
    @(posedge clk); #1;
    MemRead = 1; MemSize = 2'd2; ALU_result = 32'h500;
    @(negedge clk);
    chk("tmo.idle_stall", mem_stall, 1);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("tmo.wait%0d_req", k), bus_req, 1);
      chk($sformatf("tmo.wait%0d_stall", k), mem_stall, 1);
      chk($sformatf("tmo.wait%0d_exc", k), mem_exc, 0);
    end
    @(posedge clk); #1;
    clear_inputs();
    bus_ack = 1; bus_rdata = 32'h99999999;
    @(negedge clk);
    chk("tmo.exc", mem_exc, 1);
    chk("tmo.code", exc_code, 7);
    chk("tmo.req", bus_req, 0);
    chk("tmo.stall", mem_stall, 0);
    chk("tmo.bad_vaddr", bad_vaddr, 32'h500);
    @(posedge clk); #1;
    bus_ack = 0;
    @(negedge clk);
    chk("tmo.exc_pulse_end", mem_exc, 0);
    chk("tmo.late_ack_req", bus_req, 0);
    chk("tmo.late_ack_stall", mem_stall, 0);
    chk("tmo.memdata", MemData, cur_md);

    // kill during WAIT: ack still consumed, FSM skips DONE, data discarded.
    @(posedge clk); #1;
    MemRead = 1; MemSize = 2'd2; ALU_result = 32'h600;
    @(posedge clk); #1;
    kill = 1; MemRead = 0;
    @(negedge clk);
    chk("kill.wait_req", bus_req, 1);
    @(posedge clk); #1;
    kill = 0; bus_ack = 1; bus_rdata = 32'h11111111;
    @(negedge clk);
    chk("kill.wait2_stall", mem_stall, 1);
    @(posedge clk); #1;
    bus_ack = 0;
    MemRead = 1; MemSize = 2'd2; ALU_result = 32'h700;
    @(negedge clk);
    chk("kill.no_done_stall", mem_stall, 1);
    chk("kill.memdata_kept", MemData, cur_md);
    chk("kill.req", bus_req, 0);
    @(posedge clk); #1;
    bus_ack = 1; bus_rdata = 32'h22222222;
    @(negedge clk);
    chk("kill.next_req", bus_req, 1);
    chk("kill.next_addr", bus_addr, 32'h700);
    @(posedge clk); #1;
    bus_ack = 0;
    @(negedge clk);
    cur_md = 32'h22222222;
    chk("kill.next_done_stall", mem_stall, 0);
    chk("kill.next_memdata", MemData, cur_md);
    @(posedge clk); #1;
    clear_inputs();

    for (int n = 0; n < 40; n++) begin
      int op;
      op = $urandom_range(0, 2);
      rv = model(op != 1, op != 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 $urandom, $urandom, $urandom, $urandom_range(1, 4));
      apply($sformatf("rnd%0d", n), rv);
    end

    // Reset in the middle of WAIT abandons the transaction.
    @(posedge clk); #1;
    MemWrite = 1; MemSize = 2'd2; ALU_result = 32'h900; WriteData = 32'h87654321;
    @(posedge clk); #1;
    reset = 1; clear_inputs();
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    cur_md = 0;
    chk("midrst.req", bus_req, 0);
    chk("midrst.we", bus_we, 0);
    chk("midrst.addr", bus_addr, 0);
    chk("midrst.wdata", bus_wdata, 0);
    chk("midrst.memdata", MemData, 0);
    chk("midrst.stall", mem_stall, 0);
    chk("midrst.exc", mem_exc, 0);
    apply("postrst", tbl[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
